user_au_sample_out: RTL and testbench

- OBI subordinate in the user domain, mapped at the UserAuFilters window (0x2000_1000, 4 KB); it is the responder end of the user demux port.
- The CPU pushes 16-bit audio samples into an internal FIFO over OBI.
- A programmable sample-rate divider pops one sample per tick toward the audio output path.
- Status, underrun tracking and a low-watermark interrupt let software refill the FIFO in time.

---
 rtl/user_au_sample_out.sv | 240 ++++++++++++++++++++++++
 tb/tb_user_au_sample_out.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_au_sample_out.sv
// user_au_sample_out: OBI subordinate that buffers 16-bit audio samples in a
// FIFO and releases one sample per programmable divider tick.

package user_au_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } obi_r_t;

    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } obi_rsp_t;

endpackage

module user_au_sample_out #(
    parameter int  FifoDepth = 16,
    parameter type obi_req_t = user_au_pkg::obi_req_t,
    parameter type obi_rsp_t = user_au_pkg::obi_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    obi_req_i,
    output obi_rsp_t    obi_rsp_o,
    output logic [15:0] sample_o,
    output logic        sample_valid_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FifoDepth);
    localparam int LW = AW + 1;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_STATUS = 2'd1;
    localparam logic [1:0] SEL_DATA   = 2'd2;
    localparam logic [1:0] SEL_DIV    = 2'd3;

    // Register state
    logic          r_en;
    logic [LW-1:0] r_thr;
    logic [15:0]   r_div;
    logic [15:0]   r_cnt;
    logic          r_underrun;
    logic [15:0]   r_sample;
    logic          r_svalid;
    obi_rsp_t      r_rsp;

    // FIFO storage
    logic [15:0]   r_mem [FifoDepth];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    // Decode / datapath wires
    logic          w_acc;
    logic [11:0]   w_off;
    logic          w_in_range;
    logic [1:0]    w_sel;
    logic          w_wr;
    logic          w_clr;
    logic          w_data_wr;
    logic          w_div_wr;
    logic          w_status_w1c;
    logic          w_full;
    logic          w_empty;
    logic          w_tick;
    logic          w_pop_raw;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [31:0]   w_rdata;
    logic          w_err;
    logic          w_unused;

    assign w_acc        = obi_req_i.req;
    assign w_off        = obi_req_i.a.addr[11:0];
    assign w_in_range   = (w_off < 12'h010);
    assign w_sel        = w_off[3:2];
    assign w_wr         = w_acc && obi_req_i.a.we && w_in_range;
    assign w_clr        = w_wr && (w_sel == SEL_CTRL) && obi_req_i.a.wdata[1];
    assign w_data_wr    = w_wr && (w_sel == SEL_DATA);
    assign w_div_wr     = w_wr && (w_sel == SEL_DIV);
    assign w_status_w1c = w_wr && (w_sel == SEL_STATUS) && obi_req_i.a.wdata[10];

    // Byte enables, upper address bits and unused wdata bits carry no meaning here
    assign w_unused = ^obi_req_i;

    assign w_full  = (r_level == LW'(FifoDepth));
    assign w_empty = (r_level == '0);

    // Tick fires on the cycle the counter matches the divider
    assign w_tick    = r_en && (r_cnt == r_div);
    assign w_pop_raw = w_tick && !w_empty;
    // Clear dominates every FIFO movement so sample_o stays put
    assign w_pop     = w_pop_raw && !w_clr;
    // A full FIFO still accepts a push when the same cycle frees an entry
    assign w_push    = w_data_wr && !w_clr && (!w_full || w_pop_raw);
    assign w_drop    = w_data_wr && !w_clr && w_full && !w_pop_raw;

    // Read mux and error generation for the access being accepted
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (!w_in_range) begin
            w_err = 1'b1;
        end else if (!obi_req_i.a.we) begin
            case (w_sel)
                SEL_CTRL: begin
                    w_rdata[0]       = r_en;
                    w_rdata[8 +: LW] = r_thr;
                end
                SEL_STATUS: w_rdata = {21'd0, r_underrun, w_empty, w_full, 1'b0, 7'(r_level)};
                SEL_DATA:   w_rdata = {16'd0, r_sample};
                default:    w_rdata = {16'd0, r_div};
            endcase
        end else begin
            w_err = w_drop;
        end
    end

    // OBI response: registered one cycle after acceptance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp <= '0;
        end else begin
            r_rsp.rvalid  <= w_acc;
            r_rsp.r.rid   <= w_acc ? obi_req_i.a.aid : '0;
            r_rsp.r.rdata <= w_acc ? w_rdata : '0;
            r_rsp.r.err   <= w_acc ? w_err : 1'b0;
        end
    end

    // Grant is unconditional; everything else comes from the response register
    always_comb begin
        obi_rsp_o     = r_rsp;
        obi_rsp_o.gnt = 1'b1;
    end

    // Control and divider registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_en  <= 1'b0;
            r_thr <= '0;
            r_div <= '0;
        end else begin
            if (w_wr && (w_sel == SEL_CTRL)) begin
                r_en  <= obi_req_i.a.wdata[0];
                r_thr <= obi_req_i.a.wdata[8 +: LW];
            end
            if (w_div_wr) begin
                r_div <= obi_req_i.a.wdata[15:0];
            end
        end
    end

    // Tick counter: idles at 0 while disabled, restarts on any divider write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_div_wr || !r_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Sticky underrun; a set in the same cycle as the W1C clear wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_underrun <= 1'b0;
        end else if (w_tick && w_empty) begin
            r_underrun <= 1'b1;
        end else if (w_status_w1c) begin
            r_underrun <= 1'b0;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wptr] <= obi_req_i.a.wdata[15:0];
        end
    end

    // Output sample register and its one-cycle valid strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample <= '0;
            r_svalid <= 1'b0;
        end else begin
            r_svalid <= w_pop;
            if (w_pop) r_sample <= r_mem[r_rptr];
        end
    end

    assign sample_o       = r_sample;
    assign sample_valid_o = r_svalid;
    assign irq_o          = r_en && (r_level <= r_thr);

endmodule

// File: tb/tb_user_au_sample_out.sv
// Scoreboard bench for user_au_sample_out: OBI responses and output samples
// are predicted at stimulus time and compared when the DUT produces them.

module tb_user_au_sample_out;
    import user_au_pkg::*;

    localparam logic [31:0] BASE   = 32'h2000_1000;
    localparam logic [31:0] CTRL   = BASE + 32'h000;
    localparam logic [31:0] STATUS = BASE + 32'h004;
    localparam logic [31:0] DATA   = BASE + 32'h008;
    localparam logic [31:0] DIV    = BASE + 32'h00C;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] mask;
        logic        err;
        logic [3:0]  rid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    obi_req_t    req;
    obi_rsp_t    rsp;
    logic [15:0] smp;
    logic        sv;
    logic        irq;

    exp_t        sb_q[$];
    logic [15:0] smp_q[$];
    int          pulse_cyc[$];
    int          cyc;
    int          n_chk;
    int          n_err;
    logic [3:0]  aid_ctr;
    logic        pend_q;

    always #5 clk = ~clk;

    user_au_sample_out #(.FifoDepth(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .obi_req_i      (req),
        .obi_rsp_o      (rsp),
        .sample_o       (smp),
        .sample_valid_o (sv),
        .irq_o          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Cycle counter and record of which cycles carried an accepted request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    <= 0;
            pend_q <= 1'b0;
        end else begin
            cyc    <= cyc + 1;
            pend_q <= req.req;
        end
    end

    // Response and sample monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pend_q || rsp.rvalid) chk("rvalid", rsp.rvalid, pend_q);
            if (rsp.rvalid) begin
                if (sb_q.size() == 0) chk("rsp_unexp", rsp.rvalid, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("rid", rsp.r.rid, e.rid);
                    chk("err", rsp.r.err, e.err);
                    chk("rdata", rsp.r.rdata & e.mask, e.rdata);
                end
            end
            if (sv) begin
                pulse_cyc.push_back(cyc);
                if (smp_q.size() == 0) chk("smp_unexp", sv, 0);
                else chk("sample", smp, smp_q.pop_front());
            end
        end
    end

    task automatic obi(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [31:0] mask, input logic exp_err);
        exp_t e;
        req.req     = 1'b1;
        req.a.addr  = addr;
        req.a.we    = we;
        req.a.be    = 4'hF;
        req.a.wdata = wd;
        req.a.aid   = aid_ctr;
        e.rdata = exp_rd & mask;
        e.mask  = mask;
        e.err   = exp_err;
        e.rid   = aid_ctr;
        sb_q.push_back(e);
        aid_ctr++;
        @(posedge clk);
        #1;
        req.req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic exp_err);
        obi(1'b1, addr, wd, 32'd0, 32'd0, exp_err);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rd, input logic [31:0] mask,
                      input logic exp_err);
        obi(1'b0, addr, 32'd0, exp_rd, mask, exp_err);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (smp_q.size() != 0 || sb_q.size() != 0); i++) @(negedge clk);
        chk("drain_smp", smp_q.size(), 0);
        chk("drain_rsp", sb_q.size(), 0);
    endtask

    initial begin
        req     = '0;
        aid_ctr = '0;
        n_chk   = 0;
        n_err   = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sample", smp, 0);
        chk("rst_svalid", sv, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rvalid", rsp.rvalid, 0);
        chk("rst_rdata", rsp.r.rdata, 0);
        chk("rst_err", rsp.r.err, 0);
        chk("gnt", rsp.gnt, 1);
        @(posedge clk);
        #1;

        // Register round trip and decode error
        wr(DIV, 32'h0000_0003, 1'b0);
        rd(DIV, 32'h0000_0003, ALL, 1'b0);
        rd(BASE + 32'h010, 32'd0, ALL, 1'b1);
        rd(CTRL, 32'd0, ALL, 1'b0);
        drain();

        // Underrun with an empty FIFO, then W1C after disabling
        wr(DIV, 32'd0, 1'b0);
        wr(CTRL, 32'h1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        wr(CTRL, 32'h0, 1'b0);
        rd(STATUS, 32'h0000_0600, ALL, 1'b0);
        drain();
        chk("undr_sample", smp, 0);
        wr(STATUS, 32'h0000_0400, 1'b0);
        rd(STATUS, 32'h0000_0200, ALL, 1'b0);
        drain();

        // Playback at DIV=3: ticks every 4 cycles
        wr(DIV, 32'd3, 1'b0);
        smp_q.push_back(16'h1111); wr(DATA, 32'h1111, 1'b0);
        smp_q.push_back(16'h2222); wr(DATA, 32'h2222, 1'b0);
        smp_q.push_back(16'h3333); wr(DATA, 32'h3333, 1'b0);
        pulse_cyc.delete();
        wr(CTRL, 32'h1, 1'b0);
        drain();
        chk("pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() >= 3) begin
            chk("gap0", pulse_cyc[1] - pulse_cyc[0], 4);
            chk("gap1", pulse_cyc[2] - pulse_cyc[1], 4);
        end
        wr(CTRL, 32'h0, 1'b0);
        rd(STATUS, 32'h0000_0200, 32'h0000_03FF, 1'b0);
        drain();
        chk("play_hold", smp, 16'h3333);
        wr(STATUS, 32'h0000_0400, 1'b0);
        rd(STATUS, 32'h0000_0200, ALL, 1'b0);
        drain();

        // Overflow: 17 pushes, last one dropped
        for (int i = 0; i < 17; i++) wr(DATA, 32'hA000 + i, (i == 16));
        rd(STATUS, 32'h0000_0110, ALL, 1'b0);
        rd(DATA, 32'h0000_3333, ALL, 1'b0);
        drain();

        // Push while full on a tick cycle is accepted; level then drops by one more pop
        smp_q.push_back(16'hA000);
        smp_q.push_back(16'hA001);
        wr(DIV, 32'd0, 1'b0);
        wr(CTRL, 32'h1, 1'b0);
        wr(DATA, 32'hA010, 1'b0);
        wr(CTRL, 32'h0, 1'b0);
        rd(STATUS, 32'h0000_000F, ALL, 1'b0);
        drain();

        // Clear coinciding with a pop: FIFO ends empty, sample_o unchanged
        wr(CTRL, 32'h1, 1'b0);
        wr(CTRL, 32'h3, 1'b0);
        wr(CTRL, 32'h0, 1'b0);
        rd(STATUS, 32'h0000_0200, 32'h0000_03FF, 1'b0);
        rd(CTRL, 32'd0, ALL, 1'b0);
        drain();
        chk("clr_hold", smp, 16'hA001);
        wr(STATUS, 32'h0000_0400, 1'b0);

        // Watermark interrupt, threshold 2
        wr(CTRL, 32'h0000_0200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            smp_q.push_back(16'hB000 + 16'(i));
            wr(DATA, 32'hB000 + i, 1'b0);
        end
        @(negedge clk);
        chk("irq_dis", irq, 0);
        wr(CTRL, 32'h0000_0201, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("irq_lvl", irq, (k >= 2));
        end
        drain();
        chk("irq_empty", irq, 1);
        chk("irq_sample", smp, 16'hB003);

        // Asynchronous reset during playback with a response in flight
        @(posedge clk);
        #1;
        req.req     = 1'b1;
        req.a.addr  = DATA;
        req.a.we    = 1'b1;
        req.a.wdata = 32'h5555;
        req.a.aid   = aid_ctr;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req.req = 1'b0;
        #1;
        chk("arst_sample", smp, 0);
        chk("arst_svalid", sv, 0);
        chk("arst_irq", irq, 0);
        chk("arst_rvalid", rsp.rvalid, 0);
        chk("arst_rdata", rsp.r.rdata, 0);
        chk("arst_err", rsp.r.err, 0);
        smp_q.delete();
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(STATUS, 32'h0000_0200, ALL, 1'b0);
        rd(CTRL, 32'd0, ALL, 1'b0);
        rd(DIV, 32'd0, ALL, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
